// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - AHB-Lite encodings, FSM state codes and byte-lane decode
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  // Little-endian byte enables for an aligned access; size 3+ never reaches here legally.
  function automatic logic [3:0] lane_decode(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    lane_decode = 4'b0001 << lo;
      2'd1:    lane_decode = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_decode = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_bytelane.sv
// rtl/ahb_sram_bytelane.sv - word-organised SRAM with per-byte write enables
module ahb_sram_bytelane
  import ahb_lite_pkg::*;
#(
  parameter int WORDS = 256,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Byte-lane write; contents are never reset.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (we[n]) mem[waddr][8*n +: 8] <= wdata[8*n +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite SRAM responder with wait states, ERROR response and write forwarding
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int         IW    = (MEM_BYTES > 4) ? $clog2(MEM_BYTES) - 2 : 1;
  localparam logic [3:0] WLAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          dp_valid;
  logic          dp_write;
  logic [IW-1:0] dp_idx;
  logic [3:0]    dp_lanes;

  logic          ready_now;
  logic          accept;
  logic          addr_bad;
  logic [IW-1:0] a_idx;
  logic          commit;
  logic [3:0]    we;
  logic [IW-1:0] raddr;
  logic [31:0]   rdata;
  logic [31:0]   rd_merged;
  logic          load_now;
  logic          bus_unused;

  assign bus_unused = ^{HTRANS[0], HBURST};

  assign ready_now = (state == ST_IDLE) || (state == ST_ERR2);
  assign accept    = HSEL & HREADY & HTRANS[1] & ready_now;
  assign addr_bad  = (HADDR >= 32'(MEM_BYTES)) || (HSIZE > HSIZE_WORD) ||
                     ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                     ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign a_idx     = HADDR[IW+1:2];

  // A write lands on the edge that closes its data phase, with HWDATA sampled there.
  assign commit = ready_now & dp_valid & dp_write;
  assign we     = commit ? dp_lanes : 4'b0000;

  // Zero-wait reads look up the live address; waited reads use the captured one.
  assign raddr = (WAIT_STATES == 0) ? a_idx : dp_idx;

  assign load_now = (WAIT_STATES == 0) ? (accept & ~addr_bad & ~HWRITE)
                                       : ((state == ST_WAIT) && (cnt == WLAST) && dp_valid && !dp_write);

  // Merge lanes of a write committing on the same edge into the word being loaded.
  always_comb begin
    rd_merged = rdata;
    for (int n = 0; n < 4; n++) begin
      if (commit && dp_lanes[n] && (dp_idx == raddr)) rd_merged[8*n +: 8] = HWDATA[8*n +: 8];
    end
  end

  ahb_sram_bytelane #(.WORDS(MEM_BYTES / 4), .IW(IW)) u_mem (
    .clk   (HCLK),
    .we    (we),
    .waddr (dp_idx),
    .wdata (HWDATA),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Response FSM and wait-state counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (accept && addr_bad) begin
            state <= ST_ERR1;
          end else if (accept && (WAIT_STATES > 0)) begin
            state <= ST_WAIT;
            cnt   <= 4'd0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt == WLAST) state <= ST_IDLE;
          else              cnt   <= cnt + 4'd1;
        end
        ST_ERR1: state <= ST_ERR2;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address-phase capture; the pending data phase retires once the bus is ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_lanes <= 4'b0000;
    end else if (accept) begin
      dp_valid <= ~addr_bad;
      dp_write <= HWRITE;
      dp_idx   <= a_idx;
      dp_lanes <= lane_decode(HSIZE[1:0], HADDR[1:0]);
    end else if (ready_now) begin
      dp_valid <= 1'b0;
    end
  end

  // Registered read data; untouched by errored or write transfers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)      HRDATA <= 32'd0;
    else if (load_now) HRDATA <= rd_merged;
  end

  assign HREADYOUT = ready_now;
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - randomized scoreboard bench for the AHB-Lite SRAM slave
module tb_ahb_lite_sram_slave;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        err;
    logic        wr;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic        hwrite    [2];
  logic [1:0]  htrans    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  int   checks = 0;
  int   errors = 0;
  int   cur = 0;
  bit   mon_en = 0;
  txn_t tq[$];
  exp_t sbq[$];
  logic [7:0] mem_b [2][1024];
  bit         known [2][1024];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign hready[g] = hreadyout[g];
    ahb_lite_sram_slave #(.MEM_BYTES(1024), .WAIT_STATES(g == 0 ? 0 : 2)) u_dut (
      .HCLK      (clk),
      .HRESETn   (rst_n),
      .HSEL      (hsel[g]),
      .HADDR     (haddr[g]),
      .HWRITE    (hwrite[g]),
      .HTRANS    (htrans[g]),
      .HSIZE     (hsize[g]),
      .HBURST    (hburst[g]),
      .HWDATA    (hwdata[g]),
      .HREADY    (hready[g]),
      .HREADYOUT (hreadyout[g]),
      .HRESP     (hresp[g]),
      .HRDATA    (hrdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", name, cur, act, exp);
    end
  endtask

  // Reference: plain byte memory, transfers applied in bus order.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    int a;
    int base;
    e.wr   = t.wr;
    e.data = 32'd0;
    e.mask = 32'd0;
    e.err  = (t.addr >= 32'd1024) || (t.size > 3'd2) ||
             (t.size == 3'd1 && t.addr[0]) || (t.size == 3'd2 && t.addr[1:0] != 2'b00);
    if (!e.err) begin
      a = int'(t.addr);
      base = a - (a % 4);
      if (t.wr) begin
        for (int k = 0; k < (1 << t.size); k++) begin
          mem_b[cur][a+k] = t.wdata[8*((a+k)%4) +: 8];
          known[cur][a+k] = 1'b1;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          e.data[8*k +: 8] = mem_b[cur][base+k];
          e.mask[8*k +: 8] = known[cur][base+k] ? 8'hFF : 8'h00;
        end
      end
    end
    return e;
  endfunction

  function automatic txn_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata, input logic [1:0] trans, input logic [2:0] burst);
    txn_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata; t.trans = trans; t.burst = burst;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int r;
    t = mk(1'($urandom_range(0, 1)), 32'd0, 3'($urandom_range(0, 2)), $urandom, 2'b10, 3'd0);
    r = $urandom_range(0, 99);
    case (t.size)
      3'd0:    t.addr = 32'($urandom_range(0, 127));
      3'd1:    t.addr = 32'($urandom_range(0, 63) * 2);
      default: t.addr = 32'($urandom_range(0, 31) * 4);
    endcase
    if (r < 10)      t.trans = 2'b00;
    else if (r < 14) t.addr  = 32'h400 + 32'($urandom_range(0, 7) * 4);
    else if (r < 17) t.size  = 3'($urandom_range(3, 7));
    else if (r < 20) t.addr  = t.addr | 32'd1;
    else if (r < 24) t.addr  = 32'h3FC;
    if (r >= 20 && r < 24) t.size = 3'd2;
    return t;
  endfunction

  task automatic present(input txn_t t, input bit valid);
    hsel[cur]   = valid;
    htrans[cur] = valid ? t.trans : 2'b00;
    haddr[cur]  = t.addr;
    hwrite[cur] = t.wr;
    hsize[cur]  = t.size;
    hburst[cur] = t.burst;
  endtask

  // Pipelined master: the next address phase is issued on every ready edge.
  task automatic drive_all();
    txn_t a;
    bit   have_a;
    bit   rdy;
    int   guard = 0;
    @(negedge clk);
    have_a = tq.size() > 0;
    if (have_a) a = tq.pop_front();
    present(a, have_a);
    while (have_a) begin
      rdy = hreadyout[cur];
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        checks++;
        errors++;
        $display("FAIL timeout dut%0d got stalled want ready", cur);
        break;
      end
      if (rdy) begin
        if (a.trans[1]) begin
          sbq.push_back(model(a));
          hwdata[cur] = a.wdata;
        end
        have_a = tq.size() > 0;
        if (have_a) a = tq.pop_front();
        present(a, have_a);
      end
    end
    present(a, 1'b0);
    repeat (8) @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  // Monitor: checks every cycle against the oldest outstanding data phase.
  always begin
    static int waitc = 0;
    exp_t e;
    @(negedge clk);
    #1;
    if (!mon_en) begin
      waitc = 0;
    end else if (sbq.size() == 0) begin
      chk("idle_ready", 32'(hreadyout[cur]), 32'd1);
      chk("idle_resp", 32'(hresp[cur]), 32'd0);
    end else begin
      e = sbq[0];
      chk("resp", 32'(hresp[cur]), 32'(e.err));
      if (!hreadyout[cur]) begin
        waitc++;
      end else begin
        chk("wait_cycles", 32'(waitc), e.err ? 32'd1 : 32'(ws_of(cur)));
        if (!e.err && !e.wr) chk("rdata", hrdata[cur] & e.mask, e.data & e.mask);
        void'(sbq.pop_front());
        waitc = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; haddr[d] = 32'd0; hwrite[d] = 1'b0; htrans[d] = 2'b00;
      hsize[d] = 3'd0; hburst[d] = 3'd0; hwdata[d] = 32'd0;
      for (int i = 0; i < 1024; i++) begin
        mem_b[d][i] = 8'h00;
        known[d][i] = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cur = d;
      chk("rst_ready", 32'(hreadyout[d]), 32'd1);
      chk("rst_resp", 32'(hresp[d]), 32'd0);
      chk("rst_rdata", hrdata[d], 32'd0);
    end
    rst_n = 1'b1;
    cur = 0;
    mon_en = 1'b1;

    tq.push_back(mk(1, 32'h24, 3'd2, 32'h10101010, 2'b10, 3'd0));
    tq.push_back(mk(0, 32'h24, 3'd2, 32'h0, 2'b10, 3'd0));
    tq.push_back(mk(1, 32'h28, 3'd2, 32'h20202020, 2'b10, 3'd0));
    tq.push_back(mk(0, 32'h28, 3'd2, 32'h0, 2'b10, 3'd0));
    tq.push_back(mk(1, 32'h30, 3'd2, 32'h30303030, 2'b10, 3'd0));
    tq.push_back(mk(1, 32'h31, 3'd0, 32'h5555AB55, 2'b10, 3'd0));
    tq.push_back(mk(0, 32'h30, 3'd2, 32'h0, 2'b10, 3'd0));
    tq.push_back(mk(1, 32'h33, 3'd1, 32'hFFFFFFFF, 2'b10, 3'd0));
    tq.push_back(mk(0, 32'h30, 3'd2, 32'h0, 2'b10, 3'd0));
    tq.push_back(mk(0, 32'h400, 3'd2, 32'h0, 2'b10, 3'd0));
    tq.push_back(mk(0, 32'h30, 3'd2, 32'h0, 2'b10, 3'd0));
    drive_all();
    for (int i = 0; i < 150; i++) tq.push_back(rand_txn());
    drive_all();

    cur = 1;
    for (int i = 0; i < 10; i++)
      tq.push_back(mk(1, 32'h30 + 32'(4*i), 3'd2, $urandom, (i == 0) ? 2'b10 : 2'b11, 3'd1));
    for (int i = 0; i < 10; i++)
      tq.push_back(mk(0, 32'h30 + 32'(4*i), 3'd2, 32'h0, (i == 0) ? 2'b10 : 2'b11, 3'd1));
    drive_all();
    for (int i = 0; i < 150; i++) tq.push_back(rand_txn());
    drive_all();

    tq.push_back(mk(1, 32'h60, 3'd2, 32'h11111111, 2'b10, 3'd0));
    tq.push_back(mk(0, 32'h60, 3'd2, 32'h0, 2'b10, 3'd0));
    drive_all();
    mon_en = 1'b0;
    present(mk(1, 32'h60, 3'd2, 32'h22222222, 2'b10, 3'd0), 1'b1);
    @(negedge clk);
    hwdata[cur] = 32'h22222222;
    present(mk(0, 32'h0, 3'd0, 32'h0, 2'b00, 3'd0), 1'b0);
    chk("wait_before_rst", 32'(hreadyout[cur]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(hreadyout[cur]), 32'd1);
    chk("async_rst_resp", 32'(hresp[cur]), 32'd0);
    chk("async_rst_rdata", hrdata[cur], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tq.push_back(mk(0, 32'h60, 3'd2, 32'h0, 2'b10, 3'd0));
    drive_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
